// File: rtl/instruction_fetch_unit_if.sv
// Bundles the instruction-memory read port and the fetch-to-decode handshake.
// master = fetch unit side, slave = memory/decode side.
interface instruction_fetch_unit_if #(
    parameter int unsigned Width = 32
);
    logic             inst_mem_en;
    logic [Width-1:0] inst_mem_addr;
    logic             inst_mem_ack;
    logic [31:0]      inst_mem_rd_dat;
    logic             inst_valid;
    logic             inst_ready;
    logic [31:0]      inst;
    logic [Width-1:0] inst_pc;
    logic             inst_misaligned;

    modport master (
        output inst_mem_en, inst_mem_addr,
        input  inst_mem_ack, inst_mem_rd_dat,
        output inst_valid, inst, inst_pc, inst_misaligned,
        input  inst_ready
    );

    modport slave (
        input  inst_mem_en, inst_mem_addr,
        output inst_mem_ack, inst_mem_rd_dat,
        input  inst_valid, inst, inst_pc, inst_misaligned,
        output inst_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, reads instruction memory, hands words to decode, applies redirects.
// Optional misaligned-target trap state enabled by defining FETCH_MISALIGN_TRAP_EN.
package branch_decoder_unit_pkg;
    typedef enum logic {
        PcPlus4             = 1'b0,
        PcOrReadDataPlusImm = 1'b1
    } pc_src_t;
endpackage

module instruction_fetch_unit
    import branch_decoder_unit_pkg::*;
#(
    parameter int unsigned      Width   = 32,
    parameter logic [Width-1:0] ResetPc = '0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            redirect_valid,
    input  pc_src_t                         pc_src,
    input  logic [Width-1:0]                branch_target,
    instruction_fetch_unit_if.master        bus
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {Idle, Fetch, Hold, Trap} state_t;
`else
    typedef enum logic [1:0] {Idle, Fetch, Hold} state_t;
`endif

    state_t           state_q, state_d;
    logic [Width-1:0] pc_q, pc_d;
    logic             squash_q, squash_d;
    logic [Width-1:0] squash_addr_q, squash_addr_d;
    logic             inst_valid_q, inst_valid_d;
    logic [31:0]      inst_q, inst_d;
    logic [Width-1:0] inst_pc_q, inst_pc_d;
    logic             mem_en;
    logic             redirect;
    logic [Width-1:0] load_target;

    assign redirect = redirect_valid && (pc_src == PcOrReadDataPlusImm);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d;
    logic tgt_misaligned;
    assign load_target    = branch_target;
    assign tgt_misaligned = |branch_target[1:0];
`else
    assign load_target = branch_target & ~{{(Width-2){1'b0}}, 2'b11};
`endif

    // NOTE: every value driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        squash_d      = squash_q;
        squash_addr_d = squash_addr_q;
        inst_valid_d  = inst_valid_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned_d  = misaligned_q;
`endif
        mem_en        = 1'b0;

        unique case (state_q)
            Idle: state_d = Fetch;
            Fetch: begin
                mem_en = 1'b1;
                if (redirect) begin
                    pc_d = load_target;
                    // An ack this cycle retires the outstanding access; otherwise remember to drop it.
                    if (bus.inst_mem_ack) begin
                        squash_d = 1'b0;
                    end else if (!squash_q) begin
                        squash_d      = 1'b1;
                        squash_addr_d = pc_q;
                    end
                end else if (bus.inst_mem_ack) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                    end else begin
                        inst_d       = bus.inst_mem_rd_dat;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + Width'(4);
                        state_d      = Hold;
                    end
                end
            end
            Hold: begin
                if (redirect) begin
                    pc_d         = load_target;
                    inst_valid_d = 1'b0;
                    state_d      = Fetch;
                end else if (bus.inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = Fetch;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            Trap: begin
                if (redirect) begin
                    pc_d = load_target;
                    if (!tgt_misaligned) begin
                        misaligned_d = 1'b0;
                        state_d      = Fetch;
                    end
                end
            end
`endif
            default: state_d = Idle;
        endcase

`ifdef FETCH_MISALIGN_TRAP_EN
        // Dropping en abandons any outstanding access, so there is nothing left to squash.
        if (redirect && tgt_misaligned && (state_q != Idle)) begin
            state_d      = Trap;
            squash_d     = 1'b0;
            inst_valid_d = 1'b0;
            misaligned_d = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments; reset here is synchronous and active-high.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= Idle;
            pc_q          <= ResetPc;
            squash_q      <= 1'b0;
            squash_addr_q <= ResetPc;
            inst_valid_q  <= 1'b0;
            inst_q        <= '0;
            inst_pc_q     <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            squash_q      <= squash_d;
            squash_addr_q <= squash_addr_d;
            inst_valid_q  <= inst_valid_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned_q  <= misaligned_d;
`endif
        end
    end

    // While squashing, the old address is held until its ack arrives.
    assign bus.inst_mem_en   = mem_en;
    assign bus.inst_mem_addr = squash_q ? squash_addr_q : pc_q;
    assign bus.inst_valid    = inst_valid_q;
    assign bus.inst          = inst_q;
    assign bus.inst_pc       = inst_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.inst_misaligned = misaligned_q;
`else
    assign bus.inst_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: table-driven fetches with a scoreboard,
// plus hand-written redirect, wrap, misaligned-target and reset sequences.
module tb_instruction_fetch_unit;
    import branch_decoder_unit_pkg::*;

    typedef struct {
        int unsigned lat;
        logic [31:0] data;
        int unsigned hold;
        logic [31:0] pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        redirect_valid;
    pc_src_t     pc_src;
    logic [31:0] branch_target;

    int n_vec  = 0;
    int n_miss = 0;
    exp_t sb[$];

    instruction_fetch_unit_if #(.Width(32)) bus ();

    instruction_fetch_unit #(.Width(32), .ResetPc(32'h0)) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .pc_src         (pc_src),
        .branch_target  (branch_target),
        .bus            (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        pc_src         = PcOrReadDataPlusImm;
        branch_target  = tgt;
    endtask

    task automatic clear_inputs();
        redirect_valid      = 1'b0;
        pc_src              = PcPlus4;
        branch_target       = 32'h0;
        bus.inst_mem_ack    = 1'b0;
        bus.inst_ready      = 1'b0;
    endtask

    // One complete fetch: wait for en, delay the ack, hold decode off, then accept.
    task automatic fetch_one(input vec_t v);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.inst_mem_en && n < 16) begin
            tick();
            n++;
        end
        check("en_wait", 32'(bus.inst_mem_en), 32'h1);
        check("req_addr", bus.inst_mem_addr, v.pc);
        for (int i = 0; i < int'(v.lat); i++) begin
            bus.inst_mem_ack = 1'b0;
            check("addr_stable", bus.inst_mem_addr, v.pc);
            check("valid_while_wait", 32'(bus.inst_valid), 32'h0);
            tick();
        end
        check("addr_at_ack", bus.inst_mem_addr, v.pc);
        bus.inst_mem_ack    = 1'b1;
        bus.inst_mem_rd_dat = v.data;
        sb.push_back('{pc: v.pc, inst: v.data});
        tick();
        bus.inst_mem_ack    = 1'b0;
        bus.inst_mem_rd_dat = 32'h0;
        check("valid_in_hold", 32'(bus.inst_valid), 32'h1);
        for (int i = 0; i < int'(v.hold); i++) begin
            bus.inst_ready = 1'b0;
            check("hold_no_en", 32'(bus.inst_mem_en), 32'h0);
            check("hold_inst", bus.inst, sb[0].inst);
            check("hold_pc", bus.inst_pc, sb[0].pc);
            tick();
        end
        e = sb.pop_front();
        check("inst", bus.inst, e.inst);
        check("inst_pc", bus.inst_pc, e.pc);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        check("valid_after_accept", 32'(bus.inst_valid), 32'h0);
    endtask

    // Ack the pending fetch at once and leave the word held in Hold.
    task automatic fetch_to_hold(input logic [31:0] exp_pc, input logic [31:0] data);
        check("hold_req_addr", bus.inst_mem_addr, exp_pc);
        bus.inst_mem_ack    = 1'b1;
        bus.inst_mem_rd_dat = data;
        tick();
        bus.inst_mem_ack    = 1'b0;
        check("hold_valid", 32'(bus.inst_valid), 32'h1);
        check("hold_inst_pc", bus.inst_pc, exp_pc);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{lat: 0, data: 32'h0000_0013, hold: 0, pc: 32'h0000_0000};
        vecs[1] = '{lat: 0, data: 32'h0000_0013, hold: 0, pc: 32'h0000_0004};
        vecs[2] = '{lat: 0, data: 32'h0000_0013, hold: 0, pc: 32'h0000_0008};
        vecs[3] = '{lat: 1, data: 32'h00A0_0093, hold: 0, pc: 32'h0000_000C};
        vecs[4] = '{lat: 3, data: 32'h00B0_0113, hold: 0, pc: 32'h0000_0010};
        vecs[5] = '{lat: 0, data: 32'h0020_81B3, hold: 5, pc: 32'h0000_0014};
        vecs[6] = '{lat: 2, data: 32'hFFF0_0213, hold: 1, pc: 32'h0000_0018};

        clear_inputs();
        bus.inst_mem_rd_dat = 32'h0;
        reset = 1'b1;
        tick();
        tick();
        check("rst_en", 32'(bus.inst_mem_en), 32'h0);
        check("rst_addr", bus.inst_mem_addr, 32'h0);
        check("rst_valid", 32'(bus.inst_valid), 32'h0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_inst_pc", bus.inst_pc, 32'h0);
        check("rst_misaligned", 32'(bus.inst_misaligned), 32'h0);
        reset = 1'b0;
        check("idle_en", 32'(bus.inst_mem_en), 32'h0);
        tick();
        check("fetch_en", 32'(bus.inst_mem_en), 32'h1);

        for (int i = 0; i < 7; i++) fetch_one(vecs[i]);

        // PcPlus4 redirect has no effect.
        redirect_valid = 1'b1;
        pc_src         = PcPlus4;
        branch_target  = 32'h0000_0900;
        tick();
        clear_inputs();
        check("pcplus4_noeffect", bus.inst_mem_addr, 32'h0000_001C);

        // Redirect in Fetch without ack: old address held, its ack dropped.
        do_redirect(32'h0000_0200);
        tick();
        clear_inputs();
        check("squash_addr_hold0", bus.inst_mem_addr, 32'h0000_001C);
        tick();
        check("squash_addr_hold1", bus.inst_mem_addr, 32'h0000_001C);
        bus.inst_mem_ack    = 1'b1;
        bus.inst_mem_rd_dat = 32'h0BAD_0BAD;
        tick();
        bus.inst_mem_ack = 1'b0;
        check("squash_drop_valid", 32'(bus.inst_valid), 32'h0);
        check("squash_new_addr", bus.inst_mem_addr, 32'h0000_0200);
        fetch_one('{lat: 0, data: 32'h0000_0513, hold: 0, pc: 32'h0000_0200});

        // Redirect in Hold together with inst_ready: held word dropped.
        fetch_to_hold(32'h0000_0204, 32'h1111_1111);
        bus.inst_ready = 1'b1;
        do_redirect(32'h0000_0080);
        tick();
        clear_inputs();
        check("hold_redir_valid", 32'(bus.inst_valid), 32'h0);
        check("hold_redir_en", 32'(bus.inst_mem_en), 32'h1);
        check("hold_redir_addr", bus.inst_mem_addr, 32'h0000_0080);

        // Redirect on the same cycle as ack: word dropped, target fetched next.
        do_redirect(32'h0000_0300);
        bus.inst_mem_ack    = 1'b1;
        bus.inst_mem_rd_dat = 32'h2222_2222;
        tick();
        clear_inputs();
        check("ack_redir_valid", 32'(bus.inst_valid), 32'h0);
        check("ack_redir_addr", bus.inst_mem_addr, 32'h0000_0300);

        // Second redirect while squashing only overwrites the PC.
        do_redirect(32'h0000_0400);
        tick();
        do_redirect(32'h0000_0500);
        tick();
        clear_inputs();
        check("dbl_squash_hold", bus.inst_mem_addr, 32'h0000_0300);
        bus.inst_mem_ack = 1'b1;
        tick();
        bus.inst_mem_ack = 1'b0;
        check("dbl_squash_valid", 32'(bus.inst_valid), 32'h0);
        check("dbl_squash_addr", bus.inst_mem_addr, 32'h0000_0500);
        fetch_one('{lat: 1, data: 32'h3333_3333, hold: 0, pc: 32'h0000_0500});

        // PC wrap from 0xFFFFFFFC to 0.
        fetch_to_hold(32'h0000_0504, 32'h4444_0000);
        do_redirect(32'hFFFF_FFFC);
        tick();
        clear_inputs();
        check("wrap_addr", bus.inst_mem_addr, 32'hFFFF_FFFC);
        fetch_one('{lat: 0, data: 32'h0000_0044, hold: 0, pc: 32'hFFFF_FFFC});
        fetch_one('{lat: 0, data: 32'h0000_0055, hold: 2, pc: 32'h0000_0000});

        // Misaligned redirect target.
        fetch_to_hold(32'h0000_0004, 32'h5555_5555);
        do_redirect(32'h0000_0102);
        tick();
        clear_inputs();
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            check("trap_misaligned", 32'(bus.inst_misaligned), 32'h1);
            check("trap_en", 32'(bus.inst_mem_en), 32'h0);
            check("trap_valid", 32'(bus.inst_valid), 32'h0);
            tick();
        end
        do_redirect(32'h0000_0100);
        tick();
        clear_inputs();
        check("trap_exit_misaligned", 32'(bus.inst_misaligned), 32'h0);
        check("trap_exit_en", 32'(bus.inst_mem_en), 32'h1);
`else
        check("align_misaligned", 32'(bus.inst_misaligned), 32'h0);
        check("align_en", 32'(bus.inst_mem_en), 32'h1);
`endif
        check("align_addr", bus.inst_mem_addr, 32'h0000_0100);
        fetch_one('{lat: 0, data: 32'h0000_0066, hold: 0, pc: 32'h0000_0100});

        // Reset in the middle of a fetch drops the access.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_en", 32'(bus.inst_mem_en), 32'h0);
        check("midrst_addr", bus.inst_mem_addr, 32'h0);
        check("midrst_valid", 32'(bus.inst_valid), 32'h0);
        tick();
        fetch_one('{lat: 0, data: 32'h0000_0077, hold: 0, pc: 32'h0000_0000});

        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
